// File: rtl/polaris_bus_pkg.sv
// Shared bus definitions: arbiter state encoding, transfer size codes and
// the watchdog counter width helper.
package polaris_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_I = 2'b01,
    ST_GNT_D = 2'b10
  } arb_state_e;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } master_e;

  localparam logic [1:0] SIZ_NONE = 2'b00;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  // One spare bit beyond clog2 so the count never wraps before the limit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the instruction/data masters, the arbiter and the shared
// slave; names are seen from the arbiter, which binds the slave modport.
interface bus_arbiter_if;
  logic [63:0] iadr_i;
  logic [1:0]  isiz_i;
  logic [31:0] idat_o;
  logic        iack_o;
  logic        ierr_o;

  logic [63:0] dadr_i;
  logic [1:0]  dsiz_i;
  logic        dwe_i;
  logic [63:0] ddat_i;
  logic [63:0] ddat_o;
  logic        dack_o;
  logic        derr_o;

  logic [63:0] sadr_o;
  logic [1:0]  ssiz_o;
  logic        swe_o;
  logic [63:0] sdat_o;
  logic [63:0] sdat_i;
  logic        sack_i;

  modport slave (
    input  iadr_i, isiz_i, dadr_i, dsiz_i, dwe_i, ddat_i, sdat_i, sack_i,
    output idat_o, iack_o, ierr_o, ddat_o, dack_o, derr_o,
           sadr_o, ssiz_o, swe_o, sdat_o
  );

  modport master (
    output iadr_i, isiz_i, dadr_i, dsiz_i, dwe_i, ddat_i, sdat_i, sack_i,
    input  idat_o, iack_o, ierr_o, ddat_o, dack_o, derr_o,
           sadr_o, ssiz_o, swe_o, sdat_o
  );
endinterface

// File: rtl/bus_watchdog.sv
// Grant wait counter: cleared while idle, counts unacknowledged grant cycles
// and flags expiry on the last permitted cycle. TIMEOUT=0 never expires.
module bus_watchdog
  import polaris_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int unsigned CW    = wd_width(TIMEOUT);
  localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expire && (TIMEOUT != 0)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == CW'(LIMIT));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single shared slave with a registered
// grant, a mandatory idle turnaround and a per-grant acknowledge timeout.
module bus_arbiter
  import polaris_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  bus_arbiter_if.slave   bus
);

  arb_state_e state;
  master_e    last;
  logic       i_req;
  logic       d_req;
  logic       granted;
  logic       wd_expire;
  logic       timeout;

  assign i_req   = (bus.isiz_i != SIZ_NONE);
  assign d_req   = (bus.dsiz_i != SIZ_NONE);
  assign granted = (state != ST_IDLE);
  assign timeout = granted && wd_expire && !bus.sack_i;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (!granted),
    .count   (granted && !bus.sack_i),
    .expire  (wd_expire)
  );

  // A grant ends on ack, on the owner withdrawing its request, or on timeout;
  // every ending passes through IDLE so transactions never run back to back.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= ST_IDLE;
      last  <= MST_D;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_req && d_req) begin
            state <= (last == MST_D) ? ST_GNT_I : ST_GNT_D;
          end else if (i_req) begin
            state <= ST_GNT_I;
          end else if (d_req) begin
            state <= ST_GNT_D;
          end
        end
        ST_GNT_I: begin
          if (bus.sack_i || !i_req || timeout) begin
            state <= ST_IDLE;
            last  <= MST_I;
          end
        end
        ST_GNT_D: begin
          if (bus.sack_i || !d_req || timeout) begin
            state <= ST_IDLE;
            last  <= MST_D;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slave pins and the owner's response path follow the grant combinationally.
  always_comb begin
    bus.sadr_o = '0;
    bus.ssiz_o = SIZ_NONE;
    bus.swe_o  = 1'b0;
    bus.sdat_o = '0;
    bus.idat_o = '0;
    bus.iack_o = 1'b0;
    bus.ierr_o = 1'b0;
    bus.ddat_o = '0;
    bus.dack_o = 1'b0;
    bus.derr_o = 1'b0;
    unique case (state)
      ST_GNT_I: begin
        bus.sadr_o = bus.iadr_i;
        bus.ssiz_o = bus.isiz_i;
        bus.idat_o = bus.sdat_i[31:0];
        bus.iack_o = bus.sack_i;
        bus.ierr_o = timeout && i_req;
      end
      ST_GNT_D: begin
        bus.sadr_o = bus.dadr_i;
        bus.ssiz_o = bus.dsiz_i;
        bus.swe_o  = bus.dwe_i;
        bus.sdat_o = bus.ddat_i;
        bus.ddat_o = bus.sdat_i;
        bus.dack_o = bus.sack_i;
        bus.derr_o = timeout && d_req;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter; a transaction-level model
// predicts every cycle's outputs into a queue that a monitor drains.
module tb_bus_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [63:0] sadr;
    logic [1:0]  ssiz;
    logic        swe;
    logic [63:0] sdat;
    logic [31:0] idat;
    logic        iack;
    logic        ierr;
    logic [63:0] ddat;
    logic        dack;
    logic        derr;
  } outs_t;

  outs_t expQ[$];
  int errors = 0;
  int checks = 0;

  // Model: owner 0 = nobody, 1 = instruction, 2 = data.
  int owner = 0;
  int waited = 0;
  int lastOwner = 2;
  bit modelValid = 1'b0;

  logic [63:0] curIadr = 64'h0000_0000_1000_0040;
  logic [63:0] curDadr = 64'h0000_0002_2000_0080;
  logic        curDwe  = 1'b1;
  logic [63:0] curDdat = 64'hAAAA_5555_0000_FFFF;
  logic [63:0] curSdat = 64'h1234_5678_9ABC_DEF0;

  initial begin
    bus.iadr_i = '0; bus.isiz_i = 2'b00;
    bus.dadr_i = '0; bus.dsiz_i = 2'b00; bus.dwe_i = 1'b0; bus.ddat_i = '0;
    bus.sdat_i = '0; bus.sack_i = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input logic [1:0] isiz,
                               input logic [1:0] dsiz, input logic sack);
    outs_t e;
    bit ireq, dreq, hit, ownReq;
    @(posedge clk);
    #1;
    rst_n      = rst;
    bus.isiz_i = isiz;   bus.iadr_i = curIadr;
    bus.dsiz_i = dsiz;   bus.dadr_i = curDadr;
    bus.dwe_i  = curDwe; bus.ddat_i = curDdat;
    bus.sdat_i = curSdat;
    bus.sack_i = sack;
    ireq = (isiz != 2'b00);
    dreq = (dsiz != 2'b00);
    hit  = (TO > 0) && (owner != 0) && (waited + 1 == TO) && !sack;
    e = '0;
    if (owner == 1) begin
      e.sadr = curIadr; e.ssiz = isiz; e.idat = curSdat[31:0];
      e.iack = sack;    e.ierr = hit && ireq;
    end else if (owner == 2) begin
      e.sadr = curDadr; e.ssiz = dsiz; e.swe = curDwe; e.sdat = curDdat;
      e.ddat = curSdat; e.dack = sack; e.derr = hit && dreq;
    end
    if (modelValid) expQ.push_back(e);
    ownReq = (owner == 1) ? ireq : dreq;
    if (!rst) begin
      owner = 0; waited = 0; lastOwner = 2; modelValid = 1'b1;
    end else if (owner == 0) begin
      waited = 0;
      if (ireq && dreq) owner = (lastOwner == 1) ? 2 : 1;
      else if (ireq)    owner = 1;
      else if (dreq)    owner = 2;
    end else if (sack || !ownReq || hit) begin
      lastOwner = owner;
      owner = 0;
    end else begin
      waited++;
    end
  endtask

  // Monitor: compares whatever the model predicted for the current cycle.
  initial begin
    outs_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("slave_pins", {61'd0, bus.sadr_o, bus.ssiz_o, bus.swe_o, bus.sdat_o},
                    {61'd0, e.sadr, e.ssiz, e.swe, e.sdat});
        checkOutput("imaster", {158'd0, bus.idat_o, bus.iack_o, bus.ierr_o},
                    {158'd0, e.idat, e.iack, e.ierr});
        checkOutput("dmaster", {126'd0, bus.ddat_o, bus.dack_o, bus.derr_o},
                    {126'd0, e.ddat, e.dack, e.derr});
      end
    end
  end

  initial begin
    logic [1:0] iSizCur, dSizCur, expSiz;
    logic [63:0] expAdr;
    int v;

    $display("[TB] start, TIMEOUT=%0d", TO);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
    #1;
    checkOutput("reset_ssiz", {190'd0, bus.ssiz_o}, 192'd0);

    // Single instruction request acknowledged on its first grant cycle.
    curIadr = 64'hFFFF_FFFF_FFFF_FF00;
    curSdat = 64'h0000_0000_0000_0013;
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1);
    #1;
    checkOutput("req_cycle_iack", {191'd0, bus.iack_o}, 192'd0);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1);
    #1;
    checkOutput("single_sadr", {128'd0, bus.sadr_o}, {128'd0, 64'hFFFF_FFFF_FFFF_FF00});
    checkOutput("single_ssiz", {190'd0, bus.ssiz_o}, {190'd0, 2'b10});
    checkOutput("single_iack", {191'd0, bus.iack_o}, {191'd0, 1'b1});
    checkOutput("single_idat", {160'd0, bus.idat_o}, {160'd0, 32'h0000_0013});
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);

    // Contention from reset: I first, one idle cycle, then D with its write data.
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
    curIadr = 64'h0000_0000_1000_0040;
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b1);
    #1;
    checkOutput("contend_first_i", {128'd0, bus.sadr_o}, {128'd0, curIadr});
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    #1;
    checkOutput("contend_gap", {190'd0, bus.ssiz_o}, 192'd0);
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b1);
    #1;
    checkOutput("contend_d_adr", {128'd0, bus.sadr_o}, {128'd0, curDadr});
    checkOutput("contend_d_we", {191'd0, bus.swe_o}, {191'd0, 1'b1});
    checkOutput("contend_d_dat", {128'd0, bus.sdat_o}, {128'd0, 64'hAAAA_5555_0000_FFFF});
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);

    // Continuous contention with immediate acks alternates owners.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b1);
      #1;
      expSiz = (k % 2 == 0) ? 2'b00 : 2'b10;
      expAdr = (k % 2 == 0) ? 64'd0 : (((k / 2) % 2 == 0) ? curIadr : curDadr);
      checkOutput("alt_ssiz", {190'd0, bus.ssiz_o}, {190'd0, expSiz});
      checkOutput("alt_sadr", {128'd0, bus.sadr_o}, {128'd0, expAdr});
    end
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);

    // Data grant never acknowledged: error on the TO-th grant cycle only.
    for (int k = 0; k <= TO; k++) begin
      applyStimulus(1'b1, 2'b00, 2'b10, 1'b0);
      #1;
      checkOutput("to_derr", {191'd0, bus.derr_o}, {191'd0, (k == TO)});
      checkOutput("to_dack", {191'd0, bus.dack_o}, 192'd0);
    end
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    #1;
    checkOutput("to_idle_after", {190'd0, bus.ssiz_o}, 192'd0);

    // Reset while I waits for ack drops the transfer, then I is re-granted.
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0);
    applyStimulus(1'b0, 2'b10, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0);
    #1;
    checkOutput("rst_mid_out", {188'd0, bus.ssiz_o, bus.iack_o, bus.ierr_o}, 192'd0);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1);
    #1;
    checkOutput("rst_regrant", {190'd0, bus.ssiz_o}, {190'd0, 2'b10});

    // D withdraws mid-wait; waiting I follows after the idle cycle.
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    #1;
    checkOutput("drop_d_owner", {128'd0, bus.sadr_o}, {128'd0, curDadr});
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0);
    #1;
    checkOutput("drop_no_resp", {190'd0, bus.dack_o, bus.derr_o}, 192'd0);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0);
    #1;
    checkOutput("drop_idle", {190'd0, bus.ssiz_o}, 192'd0);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1);
    #1;
    checkOutput("drop_i_grant", {128'd0, bus.sadr_o}, {128'd0, curIadr});

    // Random traffic with sticky requests so timeouts and contention both occur.
    iSizCur = 2'b10;
    dSizCur = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      v = int'($urandom_range(0, 19));
      if (v == 0) iSizCur = 2'($urandom_range(0, 3));
      if (v == 1) dSizCur = 2'($urandom_range(0, 3));
      if (v == 2) iSizCur = (iSizCur == 2'b00) ? 2'b10 : 2'b00;
      if (v == 3) dSizCur = (dSizCur == 2'b00) ? 2'b10 : 2'b00;
      curIadr = {$urandom, $urandom};
      curDadr = {$urandom, $urandom};
      curDdat = {$urandom, $urandom};
      curSdat = {$urandom, $urandom};
      curDwe  = 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 199) != 0), iSizCur, dSizCur,
                    ($urandom_range(0, 11) == 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
